// File: rtl/flex_counter_pkg.sv
// Shared types and small helpers for the flexible counter family.
package flex_counter_pkg;

  // Per-channel counting mode: direction in bit 1, stop-at-terminal in bit 0.
  typedef enum logic [1:0] {
    UP_WRAP   = 2'd0,
    UP_STOP   = 2'd1,
    DOWN_WRAP = 2'd2,
    DOWN_STOP = 2'd3
  } cnt_mode_e;

  function automatic logic mode_is_up(input cnt_mode_e m);
    return (m == UP_WRAP) || (m == UP_STOP);
  endfunction

  function automatic logic mode_is_stop(input cnt_mode_e m);
    return (m == UP_STOP) || (m == DOWN_STOP);
  endfunction

endpackage

// File: rtl/flex_counter_chan.sv
// One counter channel: next-count selection plus registered count, level flag
// and entry pulse. The unregistered pulse is exported so the parent can build
// its own registered OR across channels.
module flex_counter_chan
  import flex_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic                    count_enable,
  input  cnt_mode_e               mode,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    rollover_pulse,
  output logic                    pulse_next
);

  localparam logic [NUM_CNT_BITS-1:0] ZERO = '0;
  localparam logic [NUM_CNT_BITS-1:0] ONE  = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] next_count;
  logic [NUM_CNT_BITS-1:0] terminal;
  logic                    flag_next;
  logic                    step;
  logic                    stop_hold;
  logic                    active;

  // Up step: anything at or above R restarts at 1 (a wrap, or recovery after a
  // load / R change left the count out of range).
  function automatic logic [NUM_CNT_BITS-1:0] up_next(
    input logic [NUM_CNT_BITS-1:0] c,
    input logic [NUM_CNT_BITS-1:0] r
  );
    return (c >= r) ? ONE : c + ONE;
  endfunction

  // Down step: idle (0), out-of-range and wrap-from-1 all reload R.
  function automatic logic [NUM_CNT_BITS-1:0] down_next(
    input logic [NUM_CNT_BITS-1:0] c,
    input logic [NUM_CNT_BITS-1:0] r
  );
    return ((c == ZERO) || (c == ONE) || (c > r)) ? r : c - ONE;
  endfunction

  // Next-state selection with clear > load > step > hold priority.
  always_comb begin
    next_count = count_out;
    active     = (rollover_val != ZERO);
    terminal   = mode_is_up(mode) ? rollover_val : ONE;
    step       = count_enable && !clear && !load;
    // A STOP channel sitting on its terminal ignores further steps.
    stop_hold  = mode_is_stop(mode) && (count_out == terminal);
    if (clear) begin
      next_count = ZERO;
    end else if (load) begin
      next_count = load_val;
    end else if (count_enable) begin
      if (!active) begin
        next_count = ZERO;
      end else if (stop_hold) begin
        next_count = count_out;
      end else if (mode_is_up(mode)) begin
        next_count = up_next(count_out, rollover_val);
      end else begin
        next_count = down_next(count_out, rollover_val);
      end
    end
    flag_next  = active && (next_count == terminal);
    // A wrap landing back on the same terminal (R==1) still counts as an
    // entry; only a STOP hold is suppressed.
    pulse_next = step && active && (next_count == terminal) && !stop_hold;
  end

  // Count, flag and pulse registers, all updated on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_out      <= ZERO;
      rollover_flag  <= 1'b0;
      rollover_pulse <= 1'b0;
    end else begin
      count_out      <= next_count;
      rollover_flag  <= flag_next;
      rollover_pulse <= pulse_next;
    end
  end

endmodule

// File: rtl/multi_flex_counter.sv
// Bank of independent flexible counters sharing clock and reset. Each channel
// takes its own slice of the packed control buses; the top only slices and
// registers the cross-channel any_rollover summary.
module multi_flex_counter
  import flex_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4,
  parameter int NUM_CH       = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              clear,
  input  logic [NUM_CH-1:0]              load,
  input  logic [NUM_CH-1:0]              count_enable,
  input  logic [2*NUM_CH-1:0]            mode,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val,
  output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
  output logic [NUM_CH-1:0]              rollover_flag,
  output logic [NUM_CH-1:0]              rollover_pulse,
  output logic                           any_rollover
);

  logic [NUM_CH-1:0] pulse_next;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    flex_counter_chan #(
      .NUM_CNT_BITS (NUM_CNT_BITS)
    ) u_chan (
      .clk            (clk),
      .rst            (rst),
      .clear          (clear[c]),
      .load           (load[c]),
      .count_enable   (count_enable[c]),
      .mode           (cnt_mode_e'(mode[2*c +: 2])),
      .rollover_val   (rollover_val[NUM_CNT_BITS*c +: NUM_CNT_BITS]),
      .load_val       (load_val[NUM_CNT_BITS*c +: NUM_CNT_BITS]),
      .count_out      (count_out[NUM_CNT_BITS*c +: NUM_CNT_BITS]),
      .rollover_flag  (rollover_flag[c]),
      .rollover_pulse (rollover_pulse[c]),
      .pulse_next     (pulse_next[c])
    );
  end

  // Summary flag registered from the same next-pulse terms so it lines up
  // exactly with rollover_pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      any_rollover <= 1'b0;
    end else begin
      any_rollover <= |pulse_next;
    end
  end

endmodule
